// File: rtl/player_ctrl.sv
// Two-player paddle position controller.
// Buttons are synchronized, sampled once per frame on the rising edge of
// frame_i, and fed to one IDLE/SLOW/FAST acceleration FSM per player.
// Positions are clamped to [POS_MIN, POS_MAX].
module player_ctrl #(
    parameter int POS_MIN      = 20,
    parameter int POS_MAX      = 420,
    parameter int POS_INIT     = 220,
    parameter int STEP_SLOW    = 2,
    parameter int STEP_FAST    = 6,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic       px_clk,
    input  logic       reset_n,
    input  logic       frame_i,
    input  logic       center_i,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] pos_ply1,
    output logic [9:0] pos_ply2,
    output logic       tick_o
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_SLOW = 2'd1;
    localparam logic [1:0]  S_FAST = 2'd2;
    localparam logic [1:0]  DIR_UP = 2'b01;
    localparam logic [1:0]  DIR_DN = 2'b10;
    localparam logic [1:0]  CMD_NONE = 2'b00;
    localparam logic [10:0] L_MIN  = 11'(POS_MIN);
    localparam logic [10:0] L_MAX  = 11'(POS_MAX);
    localparam logic [9:0]  L_INIT = 10'(POS_INIT);
    localparam logic [10:0] L_SLOW = 11'(STEP_SLOW);
    localparam logic [10:0] L_FAST = 11'(STEP_FAST);
    localparam logic [7:0]  L_ACC  = 8'(ACCEL_FRAMES);

    // Both pressed or neither pressed collapse to "no command".
    function automatic logic [1:0] cmd_of(input logic up, input logic dn);
        if (up && !dn)
            return DIR_UP;
        else if (dn && !up)
            return DIR_DN;
        else
            return CMD_NONE;
    endfunction

    // Move one step in 11-bit arithmetic, saturating at the screen limits.
    function automatic logic [9:0] step_pos(input logic [9:0]  pos,
                                            input logic [1:0]  dir,
                                            input logic [10:0] step);
        logic [10:0] ext;
        ext = {1'b0, pos};
        if (dir == DIR_UP)
            return (ext < L_MIN + step) ? 10'(L_MIN) : 10'(ext - step);
        else
            return (ext + step > L_MAX) ? 10'(L_MAX) : 10'(ext + step);
    endfunction

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic        r_frame_d;
    logic        w_tick;
    logic [1:0]  w_cmd      [2];
    logic [1:0]  r_state    [2];
    logic [1:0]  r_dir      [2];
    logic [7:0]  r_cnt      [2];
    logic [9:0]  r_pos      [2];
    logic [1:0]  w_state_nx [2];
    logic [1:0]  w_dir_nx   [2];
    logic [7:0]  w_cnt_nx   [2];
    logic        w_move     [2];
    logic [10:0] w_step     [2];
    logic [9:0]  w_pos_nx   [2];

    assign w_tick   = frame_i & ~r_frame_d;
    assign w_cmd[0] = cmd_of(r_sync2[0], r_sync2[1]);
    assign w_cmd[1] = cmd_of(r_sync2[2], r_sync2[3]);
    assign pos_ply1 = r_pos[0];
    assign pos_ply2 = r_pos[1];

    // Two-flop button synchronizers, frame_i delay copy and registered tick.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_frame_d <= 1'b0;
            tick_o    <= 1'b0;
        end else begin
            r_sync1   <= {p2_dn, p2_up, p1_dn, p1_up};
            r_sync2   <= r_sync1;
            r_frame_d <= frame_i;
            tick_o    <= w_tick;
        end
    end

    // Per-player state register: FSM state, direction, accel count, position.
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= S_IDLE;
                r_dir[p]   <= DIR_UP;
                r_cnt[p]   <= '0;
                r_pos[p]   <= L_INIT;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= w_state_nx[p];
                r_dir[p]   <= w_dir_nx[p];
                r_cnt[p]   <= w_cnt_nx[p];
                r_pos[p]   <= w_pos_nx[p];
            end
        end
    end

    // Next-state logic; center overrides a coincident tick.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_state_nx[p] = r_state[p];
            w_dir_nx[p]   = r_dir[p];
            w_cnt_nx[p]   = r_cnt[p];
            w_move[p]     = 1'b0;
            w_step[p]     = L_SLOW;
            if (center_i) begin
                w_state_nx[p] = S_IDLE;
                w_cnt_nx[p]   = '0;
            end else if (w_tick) begin
                if (w_cmd[p] == CMD_NONE) begin
                    w_state_nx[p] = S_IDLE;
                    w_cnt_nx[p]   = '0;
                end else if (r_state[p] == S_IDLE || w_cmd[p] != r_dir[p]) begin
                    w_state_nx[p] = S_SLOW;
                    w_dir_nx[p]   = w_cmd[p];
                    w_cnt_nx[p]   = 8'd1;
                    w_move[p]     = 1'b1;
                end else if (r_state[p] == S_SLOW) begin
                    w_move[p] = 1'b1;
                    if (r_cnt[p] == L_ACC) begin
                        w_state_nx[p] = S_FAST;
                        w_step[p]     = L_FAST;
                    end else begin
                        w_cnt_nx[p] = r_cnt[p] + 8'd1;
                    end
                end else begin
                    w_move[p] = 1'b1;
                    w_step[p] = L_FAST;
                end
            end
        end
    end

    // Output logic: next position (recentre, clamped step, or hold).
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_pos_nx[p] = r_pos[p];
            if (center_i)
                w_pos_nx[p] = L_INIT;
            else if (w_move[p])
                w_pos_nx[p] = step_pos(r_pos[p], w_dir_nx[p], w_step[p]);
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Testbench for player_ctrl: a behavioural model predicts both positions at
// every frame tick; predictions are queued and compared when tick_o pulses.
module tb_player_ctrl;

    localparam int POS_MIN = 20, POS_MAX = 420, POS_INIT = 220;
    localparam int STEP_SLOW = 2, STEP_FAST = 6, ACCEL_FRAMES = 8;

    logic       px_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       frame_i = 1'b0;
    logic       center_i = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [9:0] pos_ply1, pos_ply2;
    logic       tick_o;

    int n_checks = 0;
    int n_pass   = 0;
    int q1[$];
    int q2[$];

    int m_st[2], m_dir[2], m_cnt[2], m_pos[2];

    player_ctrl #(
        .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT),
        .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST), .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .px_clk(px_clk), .reset_n(reset_n), .frame_i(frame_i), .center_i(center_i),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .pos_ply1(pos_ply1), .pos_ply2(pos_ply2), .tick_o(tick_o)
    );

    always #5 px_clk = ~px_clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // Model state: 0 idle, 1 slow, 2 fast; direction 1 up, 2 down.
    task automatic model_center();
        for (int p = 0; p < 2; p++) begin
            m_st[p] = 0; m_cnt[p] = 0; m_pos[p] = POS_INIT;
        end
    endtask

    task automatic model_player(input int p, input bit up, input bit dn);
        int cmd, step;
        cmd  = (up && !dn) ? 1 : (dn && !up) ? 2 : 0;
        step = 0;
        if (cmd == 0) begin
            m_st[p] = 0; m_cnt[p] = 0;
        end else if (m_st[p] == 0 || m_dir[p] != cmd) begin
            m_st[p] = 1; m_dir[p] = cmd; m_cnt[p] = 1; step = STEP_SLOW;
        end else if (m_st[p] == 1) begin
            if (m_cnt[p] == ACCEL_FRAMES) begin
                m_st[p] = 2; step = STEP_FAST;
            end else begin
                m_cnt[p]++; step = STEP_SLOW;
            end
        end else begin
            step = STEP_FAST;
        end
        if (step != 0) begin
            if (cmd == 1) m_pos[p] = (m_pos[p] - step < POS_MIN) ? POS_MIN : m_pos[p] - step;
            else          m_pos[p] = (m_pos[p] + step > POS_MAX) ? POS_MAX : m_pos[p] + step;
        end
    endtask

    // One frame: settle buttons, raise frame_i (optionally with center), predict.
    task automatic frame_tick(input bit ctr);
        repeat (4) @(negedge px_clk);
        frame_i  = 1'b1;
        center_i = ctr;
        if (ctr) begin
            model_center();
        end else begin
            model_player(0, p1_up, p1_dn);
            model_player(1, p2_up, p2_dn);
        end
        q1.push_back(m_pos[0]);
        q2.push_back(m_pos[1]);
        @(negedge px_clk);
        center_i = 1'b0;
        repeat (2) @(negedge px_clk);
        frame_i = 1'b0;
    endtask

    task automatic center_pulse();
        @(negedge px_clk);
        center_i = 1'b1;
        model_center();
        @(negedge px_clk);
        center_i = 1'b0;
        check_eq("center_p1", int'(pos_ply1), POS_INIT);
        check_eq("center_p2", int'(pos_ply2), POS_INIT);
    endtask

    // Scoreboard consumer: every tick_o pulse must match the oldest prediction.
    always @(negedge px_clk) begin
        if (reset_n && tick_o) begin
            if (q1.size() == 0) begin
                check_eq("unexpected_tick", 1, 0);
            end else begin
                check_eq("tick_p1", int'(pos_ply1), q1.pop_front());
                check_eq("tick_p2", int'(pos_ply2), q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        // Reset state
        #3 reset_n = 1'b0;
        repeat (3) @(negedge px_clk);
        check_eq("rst_p1", int'(pos_ply1), POS_INIT);
        check_eq("rst_p2", int'(pos_ply2), POS_INIT);
        check_eq("rst_tick", int'(tick_o), 0);
        reset_n = 1'b1;
        model_center();
        m_dir[0] = 1; m_dir[1] = 1;

        // Player 1 down for three ticks
        p1_dn = 1'b1;
        repeat (3) frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("dn3_p1", int'(pos_ply1), 226);
        check_eq("dn3_p2", int'(pos_ply2), 220);
        p1_dn = 1'b0;
        frame_tick(1'b0);

        // Player 2 up for twelve ticks: slow then fast
        p2_up = 1'b1;
        repeat (12) frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("accel_p2", int'(pos_ply2), 180);
        check_eq("accel_p1", int'(pos_ply1), 226);
        p2_up = 1'b0;

        // Player 1 down into the lower limit and hold there
        center_pulse();
        p1_dn = 1'b1;
        repeat (42) frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("clamp_p1", int'(pos_ply1), POS_MAX);

        // Reverse from FAST, then both buttons, then down again from IDLE
        p1_dn = 1'b0; p1_up = 1'b1;
        frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("reverse_p1", int'(pos_ply1), 418);
        p1_dn = 1'b1;
        repeat (2) frame_tick(1'b0);
        p1_up = 1'b0;
        frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("idle_restart_p1", int'(pos_ply1), 420);

        // Player 2 up to the top limit
        p1_dn = 1'b0; p2_up = 1'b1;
        repeat (40) frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("clamp_p2", int'(pos_ply2), POS_MIN);
        p2_up = 1'b0;

        // Center coincident with a tick while both players move
        p1_up = 1'b1; p2_dn = 1'b1;
        repeat (3) frame_tick(1'b0);
        frame_tick(1'b1);
        repeat (3) @(negedge px_clk);
        check_eq("ctr_tick_p1", int'(pos_ply1), POS_INIT);
        check_eq("ctr_tick_p2", int'(pos_ply2), POS_INIT);
        p1_up = 1'b0; p2_dn = 1'b0;
        frame_tick(1'b0);

        // Short button pulse between ticks has no effect
        repeat (2) @(negedge px_clk);
        p1_up = 1'b1; p2_dn = 1'b1;
        repeat (3) @(negedge px_clk);
        p1_up = 1'b0; p2_dn = 1'b0;
        repeat (4) @(negedge px_clk);
        frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("glitch_p1", int'(pos_ply1), POS_INIT);
        check_eq("glitch_p2", int'(pos_ply2), POS_INIT);

        // Random traffic on both players
        for (int i = 0; i < 25; i++) begin
            p1_up = 1'($urandom_range(0, 1)); p1_dn = 1'($urandom_range(0, 1));
            p2_up = 1'($urandom_range(0, 1)); p2_dn = 1'($urandom_range(0, 1));
            frame_tick(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        // Reset during a tick cycle discards the pending move
        p1_dn = 1'b1; p2_up = 1'b1;
        repeat (5) frame_tick(1'b0);
        repeat (4) @(negedge px_clk);
        frame_i = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_p1", int'(pos_ply1), POS_INIT);
        check_eq("async_rst_p2", int'(pos_ply2), POS_INIT);
        repeat (2) @(negedge px_clk);
        check_eq("async_rst_tick", int'(tick_o), 0);
        frame_i = 1'b0;
        p1_dn = 1'b0; p2_up = 1'b0;
        model_center();
        @(negedge px_clk);
        reset_n = 1'b1;

        // First tick after reset release
        p2_dn = 1'b1;
        frame_tick(1'b0);
        repeat (3) @(negedge px_clk);
        check_eq("post_rst_p2", int'(pos_ply2), 222);
        check_eq("pending_empty", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
